// File: rtl/sump_cmd_assembler.sv
// Assembles SUMP protocol bytes into commands: 1-byte short commands and
// 5-byte long commands (opcode plus 32-bit little-endian argument).
module sump_cmd_assembler #(
  parameter int TIMEOUT = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        cmd_timeout,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ARG  = 1'b1;

  localparam logic [31:0] LAST_IDLE = 32'(TIMEOUT - 1);

  logic [0:0]  state;
  logic [1:0]  idx;
  logic [31:0] counter;
  logic [7:0]  opcode_shadow;
  logic [23:0] arg_shadow;

  assign busy = (state == ARG);

  // The final argument byte goes straight to config_data, so the shadow
  // only needs to hold the first three.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= 2'd0;
      counter       <= 32'd0;
      opcode_shadow <= 8'h00;
      arg_shadow    <= 24'h0;
      opcode        <= 8'h00;
      config_data   <= 32'h0;
      execute       <= 1'b0;
      cmd_timeout   <= 1'b0;
    end else begin
      execute     <= 1'b0;
      cmd_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (!rx_data[7]) begin
              execute     <= 1'b1;
              opcode      <= rx_data;
              config_data <= 32'h0;
            end else begin
              opcode_shadow <= rx_data;
              arg_shadow    <= 24'h0;
              idx           <= 2'd0;
              counter       <= 32'd0;
              state         <= ARG;
            end
          end
        end
        ARG: begin
          if (rx_valid) begin
            counter <= 32'd0;
            idx     <= idx + 2'd1;
            case (idx)
              2'd0: arg_shadow[7:0]   <= rx_data;
              2'd1: arg_shadow[15:8]  <= rx_data;
              2'd2: arg_shadow[23:16] <= rx_data;
              default: begin
                state       <= IDLE;
                execute     <= 1'b1;
                opcode      <= opcode_shadow;
                config_data <= {rx_data, arg_shadow};
              end
            endcase
          end else if (counter == LAST_IDLE) begin
            // Abandon the partial command; visible outputs stay as they were.
            state       <= IDLE;
            cmd_timeout <= 1'b1;
            counter     <= 32'd0;
            idx         <= 2'd0;
            arg_shadow  <= 24'h0;
          end else if (counter != 32'hFFFF_FFFF) begin
            counter <= counter + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sump_cmd_assembler.sv
// Self-checking bench for sump_cmd_assembler: directed table, corner-case
// sequences and randomized traffic against a command-level reference model.
module tb_sump_cmd_assembler;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute;
  logic        cmd_timeout;
  logic        busy;

  sump_cmd_assembler #(.TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .opcode      (opcode),
    .config_data (config_data),
    .execute     (execute),
    .cmd_timeout (cmd_timeout),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;
  int exec_seen = 0;
  int tmo_seen  = 0;

  // Reference model: a command is a pending opcode plus a list of argument
  // bytes; a long command completes at four arguments or dies after
  // TIMEOUT consecutive silent cycles.
  bit          m_long = 1'b0;
  logic [7:0]  m_pending_op = 8'h00;
  logic [7:0]  m_args[$];
  int          m_idle = 0;
  logic [7:0]  m_opcode = 8'h00;
  logic [31:0] m_config = 32'h0;
  bit          m_execute = 1'b0;
  bit          m_timeout = 1'b0;

  function automatic void model_step(bit r, bit v, logic [7:0] d);
    if (r) begin
      m_long = 1'b0;
      m_args.delete();
      m_idle = 0;
      m_opcode = 8'h00;
      m_config = 32'h0;
      m_execute = 1'b0;
      m_timeout = 1'b0;
      return;
    end
    m_execute = 1'b0;
    m_timeout = 1'b0;
    if (!m_long) begin
      if (v) begin
        if (d < 8'h80) begin
          m_execute = 1'b1;
          m_opcode = d;
          m_config = 32'h0;
        end else begin
          m_long = 1'b1;
          m_pending_op = d;
          m_args.delete();
          m_idle = 0;
        end
      end
    end else if (v) begin
      m_args.push_back(d);
      m_idle = 0;
      if (m_args.size() == 4) begin
        m_execute = 1'b1;
        m_opcode = m_pending_op;
        m_config = m_args[0] + (m_args[1] * 256) + (m_args[2] * 65536) + (m_args[3] * 16777216);
        m_long = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_timeout = 1'b1;
        m_long = 1'b0;
      end
    end
  endfunction

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output(string tag);
    check_val({tag, ".execute"}, 32'(execute), 32'(m_execute));
    check_val({tag, ".cmd_timeout"}, 32'(cmd_timeout), 32'(m_timeout));
    check_val({tag, ".busy"}, 32'(busy), 32'(m_long));
    check_val({tag, ".opcode"}, 32'(opcode), 32'(m_opcode));
    check_val({tag, ".config_data"}, config_data, m_config);
  endtask

  // Drive one cycle of inputs, advance the model, and sample after the edge.
  task automatic apply_stimulus(bit r, bit v, logic [7:0] d);
    @(negedge clock);
    reset = r;
    rx_valid = v;
    rx_data = d;
    model_step(r, v, d);
    @(posedge clock);
    #1;
    if (execute) exec_seen++;
    if (cmd_timeout) tmo_seen++;
  endtask

  task automatic send(string tag, bit v, logic [7:0] d);
    apply_stimulus(1'b0, v, d);
    check_output(tag);
  endtask

  typedef struct {
    bit          rst;
    bit          valid;
    logic [7:0]  data;
    bit          exe;
    logic [7:0]  op;
    logic [31:0] cfg;
    bit          tmo;
    bit          bsy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int tmo_at;
    int gap_left;

    // Short command 0x02, then long command 0x81 78 56 34 12 with gaps 0..3.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 8'h02, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h81, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'h78, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h56, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h34, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 32'h0,        1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h12, 1'b1, 8'h81, 32'h12345678, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h81, 32'h12345678, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].valid, vecs[i].data);
      check_val($sformatf("vec%0d.execute", i), 32'(execute), 32'(vecs[i].exe));
      check_val($sformatf("vec%0d.opcode", i), 32'(opcode), 32'(vecs[i].op));
      check_val($sformatf("vec%0d.config_data", i), config_data, vecs[i].cfg);
      check_val($sformatf("vec%0d.cmd_timeout", i), 32'(cmd_timeout), 32'(vecs[i].tmo));
      check_val($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
    end

    // Timeout: the pulse follows the 16th silent cycle; outputs keep 81/12345678.
    send("tmo", 1'b1, 8'hC0);
    send("tmo", 1'b1, 8'h11);
    send("tmo", 1'b1, 8'h22);
    exec_seen = 0;
    tmo_at = 0;
    for (int i = 1; i <= 20; i++) begin
      send("tmo_idle", 1'b0, 8'h00);
      if (cmd_timeout && tmo_at == 0) tmo_at = i;
    end
    check_val("tmo_latency", 32'(tmo_at), 32'd16);
    check_val("tmo_no_execute", 32'(exec_seen), 32'd0);
    check_val("tmo_opcode_kept", 32'(opcode), 32'h81);
    check_val("tmo_config_kept", config_data, 32'h12345678);
    send("post_tmo", 1'b1, 8'h01);
    check_val("post_tmo_opcode", 32'(opcode), 32'h01);

    // Race: byte arrives on the 16th silent cycle and must win.
    tmo_seen = 0;
    send("race", 1'b1, 8'hC5);
    send("race", 1'b1, 8'h11);
    for (int i = 0; i < TIMEOUT - 1; i++) send("race_idle", 1'b0, 8'h00);
    send("race_hit", 1'b1, 8'h22);
    send("race", 1'b1, 8'h33);
    send("race", 1'b1, 8'h44);
    check_val("race_no_timeout", 32'(tmo_seen), 32'd0);
    check_val("race_execute", 32'(execute), 32'd1);
    check_val("race_config", config_data, 32'h44332211);

    // Back-to-back: long command immediately followed by a short one.
    send("b2b", 1'b1, 8'hC0);
    send("b2b", 1'b1, 8'hAA);
    send("b2b", 1'b1, 8'hBB);
    send("b2b", 1'b1, 8'hCC);
    send("b2b", 1'b1, 8'hDD);
    check_val("b2b_first_exec", 32'(execute), 32'd1);
    check_val("b2b_first_cfg", config_data, 32'hDDCCBBAA);
    send("b2b", 1'b1, 8'h00);
    check_val("b2b_second_exec", 32'(execute), 32'd1);
    check_val("b2b_second_op", 32'(opcode), 32'h00);
    check_val("b2b_second_cfg", config_data, 32'h0);
    send("b2b_tail", 1'b0, 8'h00);

    // Reset mid-command, with a coincident short byte that must be dropped.
    send("rst", 1'b1, 8'h81);
    send("rst", 1'b1, 8'h11);
    send("rst", 1'b1, 8'h22);
    exec_seen = 0;
    tmo_seen = 0;
    apply_stimulus(1'b1, 1'b1, 8'h05);
    check_output("rst_cycle");
    check_val("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < TIMEOUT + 4; i++) send("rst_idle", 1'b0, 8'h00);
    check_val("rst_no_strobes", 32'(exec_seen + tmo_seen), 32'd0);
    send("rst_cmd", 1'b1, 8'h81);
    send("rst_cmd", 1'b1, 8'h78);
    send("rst_cmd", 1'b1, 8'h56);
    send("rst_cmd", 1'b1, 8'h34);
    send("rst_cmd", 1'b1, 8'h12);
    check_val("rst_cmd_cfg", config_data, 32'h12345678);

    // Randomized traffic with occasional long silences and rare resets.
    gap_left = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit v;
      logic [7:0] d;
      r = ($urandom_range(0, 299) == 0);
      d = 8'($urandom);
      if (gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else begin
        v = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 24) == 0) gap_left = $urandom_range(12, 20);
      end
      apply_stimulus(r, v, d);
      check_output("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
